// File: rtl/traffic_pkg.sv
// Shared playfield geometry, palette and vehicle classification for the
// road-traffic renderer.
package traffic_pkg;

  localparam int BLOCKSIZE = 32;
  localparam int X_LEFT    = 96;
  localparam int X_RIGHT   = 544;
  localparam int LANE_Y0   = 256;

  localparam logic [5:0] C_NONE      = 6'h00;
  localparam logic [5:0] C_CAR_BODY  = 6'h30;
  localparam logic [5:0] C_CAR_GLASS = 6'h0b;
  localparam logic [5:0] C_WHEEL     = 6'h15;
  localparam logic [5:0] C_RV        = 6'h2a;
  localparam logic [5:0] C_TRUCK     = 6'h1c;
  localparam logic [5:0] C_CAB       = 6'h3c;

  typedef enum logic [1:0] {CAR, RV, TRUCK} vehicle_kind_t;

endpackage

// File: rtl/traffic_engine_if.sv
// Pixel bus between the scan generator and the traffic renderer.
interface traffic_engine_if;
  logic [9:0] colPos;
  logic [9:0] rowPos;
  logic [5:0] color;
  logic       car_hit;

  modport master (output colPos, rowPos, input color, car_hit);
  modport slave  (input colPos, rowPos, output color, car_hit);
endinterface

// File: rtl/car_rom.sv
// 32x32 car sprite, addressed {row[4:0], col[4:0]}; 0 is transparent.
module car_rom
  import traffic_pkg::*;
(
  input  logic [9:0] addr,
  output logic [5:0] data
);
  logic [4:0] row;
  logic [4:0] col;

  assign row = addr[9:5];
  assign col = addr[4:0];

  always_comb begin
    data = C_NONE;
    if (row >= 5'd2 && row <= 5'd29 && col >= 5'd1 && col <= 5'd30) begin
      if (col >= 5'd20 && col <= 5'd25 && row >= 5'd6 && row <= 5'd25)
        data = C_CAR_GLASS;
      else
        data = C_CAR_BODY;
    end else if ((row <= 5'd1 || row >= 5'd30) &&
                 ((col >= 5'd4 && col <= 5'd9) || (col >= 5'd22 && col <= 5'd27))) begin
      data = C_WHEEL;
    end
  end
endmodule

// File: rtl/lane_mover.sv
// One road lane: frame divider and the x positions of its vehicles, updated
// only on frame_tick.
module lane_mover #(
  parameter int CARS    = 2,
  parameter int X_LEFT  = 96,
  parameter int X_RIGHT = 544
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 pause,
  input  logic [9:0]           length,
  input  logic [3:0]           period,
  input  logic                 dir,
  output logic [CARS-1:0][9:0] car_x
);
  logic [3:0]           div;
  logic [3:0]           div_last;
  logic                 advance;
  logic                 step;
  logic [CARS-1:0][9:0] next_x;

  assign div_last = (period == 4'd0) ? 4'd0 : period - 4'd1;
  assign advance  = frame_tick && !pause;
  assign step     = advance && (div >= div_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      div <= 4'd0;
    else if (advance)
      div <= (div >= div_last) ? 4'd0 : div + 4'd1;
  end

  // Left wrap is judged on the stepped position, mirroring the right-hand rule.
  always_comb begin
    next_x = '0;
    for (int k = 0; k < CARS; k++) begin
      if (dir) begin
        if ({1'b0, car_x[k]} + 11'd1 >= 11'(X_RIGHT))
          next_x[k] = 10'(X_LEFT) - length;
        else
          next_x[k] = car_x[k] + 10'd1;
      end else begin
        if ({1'b0, car_x[k]} + {1'b0, length} <= 11'(X_LEFT + 1))
          next_x[k] = 10'(X_RIGHT - 1);
        else
          next_x[k] = car_x[k] - 10'd1;
      end
    end
  end

  for (genvar k = 0; k < CARS; k++) begin : g_car
    localparam logic [9:0] X_RESET = 10'(X_LEFT + k * ((X_RIGHT - X_LEFT) / CARS));
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        car_x[k] <= X_RESET;
      else if (step)
        car_x[k] <= next_x[k];
    end
  end
endmodule

// File: rtl/traffic_engine.sv
// Road traffic renderer: per-lane movers plus a 2-stage pixel pipeline that
// produces vehicle colour, hit flag and a sticky frog collision flag.
module traffic_engine #(
  parameter int NUM_LANES     = 6,
  parameter int CARS_PER_LANE = 2,
  parameter int BLOCKSIZE     = traffic_pkg::BLOCKSIZE,
  parameter int X_LEFT        = traffic_pkg::X_LEFT,
  parameter int X_RIGHT       = traffic_pkg::X_RIGHT,
  parameter int LANE_Y0       = traffic_pkg::LANE_Y0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic                      pause,
  traffic_engine_if.slave           pix,
  input  logic [NUM_LANES-1:0][9:0] lane_length,
  input  logic [NUM_LANES-1:0][3:0] lane_period,
  input  logic [NUM_LANES-1:0]      lane_dir,
  input  logic [9:0]                frog_x,
  input  logic [2:0]                frog_lane,
  output logic                      collide
);
  import traffic_pkg::*;

  logic [NUM_LANES-1:0][CARS_PER_LANE-1:0][9:0] car_x;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_mover #(
      .CARS    (CARS_PER_LANE),
      .X_LEFT  (X_LEFT),
      .X_RIGHT (X_RIGHT)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .pause      (pause),
      .length     (lane_length[i]),
      .period     (lane_period[i]),
      .dir        (lane_dir[i]),
      .car_x      (car_x[i])
    );
  end

  logic [10:0]                   row_rel;
  logic                          in_rows;
  logic                          in_win;
  logic [2:0]                    lane_c;
  logic [2:0]                    lane_sel;
  logic [4:0]                    ly_c;
  logic [CARS_PER_LANE-1:0][9:0] cx;
  logic [9:0]                    len_sel;
  logic                          hit_c;
  logic [9:0]                    lx_c;

  assign row_rel  = {1'b0, pix.rowPos} - 11'(LANE_Y0);
  assign in_rows  = ({1'b0, pix.rowPos} >= 11'(LANE_Y0)) &&
                    ({1'b0, pix.rowPos} <  11'(LANE_Y0 + NUM_LANES * BLOCKSIZE));
  assign in_win   = ({1'b0, pix.colPos} >= 11'(X_LEFT)) &&
                    ({1'b0, pix.colPos} <  11'(X_RIGHT));
  assign lane_c   = 3'(row_rel / 11'(BLOCKSIZE));
  assign ly_c     = 5'(row_rel % 11'(BLOCKSIZE));
  assign lane_sel = in_rows ? lane_c : 3'd0;
  assign cx       = car_x[lane_sel];
  assign len_sel  = lane_length[lane_sel];

  // Scan from the highest index down so the lowest-index car wins.
  always_comb begin
    hit_c = 1'b0;
    lx_c  = '0;
    for (int k = CARS_PER_LANE - 1; k >= 0; k--) begin
      if ({1'b0, pix.colPos} >= {1'b0, cx[k]} &&
          {1'b0, pix.colPos} <  {1'b0, cx[k]} + {1'b0, len_sel}) begin
        hit_c = 1'b1;
        lx_c  = pix.colPos - cx[k];
      end
    end
    if (!(in_rows && in_win))
      hit_c = 1'b0;
  end

  logic       s1_hit;
  logic [9:0] s1_lx;
  logic [4:0] s1_ly;
  logic [9:0] s1_len;
  logic [2:0] s1_lane;
  logic [9:0] s1_col;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit  <= 1'b0;
      s1_lx   <= '0;
      s1_ly   <= '0;
      s1_len  <= '0;
      s1_lane <= '0;
      s1_col  <= '0;
    end else begin
      s1_hit  <= hit_c;
      s1_lx   <= lx_c;
      s1_ly   <= ly_c;
      s1_len  <= len_sel;
      s1_lane <= lane_c;
      s1_col  <= pix.colPos;
    end
  end

  vehicle_kind_t kind;
  logic [5:0]    rom_data;
  logic [5:0]    color_c;

  car_rom u_rom (
    .addr ({s1_ly, s1_lx[4:0]}),
    .data (rom_data)
  );

  always_comb begin
    kind = TRUCK;
    if (s1_len < 10'(2 * BLOCKSIZE))
      kind = CAR;
    else if (s1_len == 10'(2 * BLOCKSIZE))
      kind = RV;
    color_c = C_NONE;
    if (s1_hit) begin
      case (kind)
        CAR:     color_c = rom_data;
        RV:      color_c = C_RV;
        default: color_c = ({1'b0, s1_lx} + 11'(BLOCKSIZE) >= {1'b0, s1_len}) ? C_CAB : C_TRUCK;
      endcase
    end
  end

  logic [2:0] s2_lane;
  logic [9:0] s2_col;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix.color   <= C_NONE;
      pix.car_hit <= 1'b0;
      s2_lane     <= '0;
      s2_col      <= '0;
    end else begin
      pix.color   <= color_c;
      pix.car_hit <= s1_hit;
      s2_lane     <= s1_lane;
      s2_col      <= s1_col;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      collide <= 1'b0;
    else if (frame_tick)
      collide <= 1'b0;
    else if (pix.car_hit && s2_lane == frog_lane &&
             {1'b0, s2_col} >= {1'b0, frog_x} &&
             {1'b0, s2_col} <  {1'b0, frog_x} + 11'(BLOCKSIZE))
      collide <= 1'b1;
  end
endmodule

// File: tb/tb_traffic_engine.sv
// Randomized scoreboard bench for traffic_engine against a frame-level
// behavioural model of lane motion and pixel rendering.
module tb_traffic_engine;
  import traffic_pkg::*;

  localparam int NL = 6;
  localparam int NC = 2;
  localparam int BS = 32;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               pause = 1'b0;
  logic [NL-1:0][9:0] lane_length;
  logic [NL-1:0][3:0] lane_period;
  logic [NL-1:0]      lane_dir;
  logic [9:0]         frog_x;
  logic [2:0]         frog_lane;
  logic               collide;

  traffic_engine_if pix();

  traffic_engine #(
    .NUM_LANES(NL), .CARS_PER_LANE(NC), .BLOCKSIZE(BS),
    .X_LEFT(96), .X_RIGHT(544), .LANE_Y0(256)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .pause(pause),
    .pix(pix), .lane_length(lane_length), .lane_period(lane_period),
    .lane_dir(lane_dir), .frog_x(frog_x), .frog_lane(frog_lane),
    .collide(collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] color;
    bit         hit;
    int         lane;
    int         col;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pos[NL][NC];
  int   ticks_seen[NL];
  bit   exp_collide = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] sprite(input int y, input int x);
    bit body, glass, wheel;
    body  = (y inside {[2:29]}) && (x inside {[1:30]});
    glass = body && (x inside {[20:25]}) && (y inside {[6:25]});
    wheel = !body && (y < 2 || y > 29) && (x inside {[4:9], [22:27]});
    if (glass) return C_CAR_GLASS;
    if (body)  return C_CAR_BODY;
    if (wheel) return C_WHEEL;
    return C_NONE;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      ticks_seen[l] = 0;
      for (int k = 0; k < NC; k++) pos[l][k] = X_LEFT + k * ((X_RIGHT - X_LEFT) / NC);
    end
  endtask

  function automatic int step_car(input int x, input int len, input bit right);
    int n;
    if (right) begin
      n = x + 1;
      if (n >= X_RIGHT) n = X_LEFT - len;
    end else begin
      n = x - 1;
      if (n + len <= X_LEFT) n = X_RIGHT - 1;
    end
    return n;
  endfunction

  task automatic model_tick();
    int p;
    if (pause) return;
    for (int l = 0; l < NL; l++) begin
      p = (lane_period[l] == 0) ? 1 : int'(lane_period[l]);
      ticks_seen[l]++;
      if (ticks_seen[l] >= p) begin
        ticks_seen[l] = 0;
        for (int k = 0; k < NC; k++)
          pos[l][k] = step_car(pos[l][k], int'(lane_length[l]), lane_dir[l]);
      end
    end
  endtask

  task automatic ref_pixel(input int col, input int row, output logic [5:0] c,
                           output bit h, output int ln);
    int len, lx;
    c = C_NONE; h = 0; ln = 0; lx = 0;
    if (row < LANE_Y0 || row >= LANE_Y0 + NL * BS || col < X_LEFT || col >= X_RIGHT) return;
    ln  = (row - LANE_Y0) / BS;
    len = int'(lane_length[ln]);
    for (int k = 0; k < NC; k++)
      if (!h && col >= pos[ln][k] && col < pos[ln][k] + len) begin
        h = 1; lx = col - pos[ln][k];
      end
    if (!h) return;
    if (len < 2 * BS)       c = sprite((row - LANE_Y0) % BS, lx % BS);
    else if (len == 2 * BS) c = C_RV;
    else                    c = (lx >= len - BS) ? C_CAB : C_TRUCK;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (reset_n) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk($sformatf("color(%0d,lane %0d)", e.col, e.lane), pix.color, e.color);
        chk($sformatf("car_hit(%0d,lane %0d)", e.col, e.lane), pix.car_hit, e.hit);
        if (e.hit && e.lane == int'(frog_lane) && e.col >= int'(frog_x) && e.col < int'(frog_x) + BS)
          exp_collide = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int col, input int row);
    exp_t e;
    @(negedge clk);
    pix.colPos = 10'(col);
    pix.rowPos = 10'(row);
    ref_pixel(col, row, e.color, e.hit, e.lane);
    e.col = col;
    e.due = cyc + 2;
    q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    pix.colPos = 10'd0;
    pix.rowPos = 10'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scan_row(input int row, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) drive(c, row);
    drain();
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    model_tick();
    exp_collide = 0;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic scan_cars();
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NC; k++)
        for (int d = -2; d <= 2; d++) begin
          drive(pos[l][k] + d, LANE_Y0 + l * BS + 5);
          drive(pos[l][k] + int'(lane_length[l]) + d, LANE_Y0 + l * BS + 20);
        end
    drain();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int row, col, l, k;
    for (int i = 0; i < NL; i++) begin
      lane_length[i] = 10'd32;
      lane_period[i] = 4'd0;
      lane_dir[i]    = 1'b1;
    end
    frog_lane  = 3'd7;
    frog_x     = 10'd0;
    pix.colPos = 10'd0;
    pix.rowPos = 10'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_color", pix.color, 0);
    chk("reset_car_hit", pix.car_hit, 0);
    chk("reset_collide", collide, 0);
    reset_n = 1'b1;

    // sprite pixel, off-road row, car edges
    drive(100, 260); drive(100, 250); drive(96, 256); drive(95, 256);
    drive(127, 287); drive(128, 287); drive(320, 270); drive(351, 270); drive(352, 270);
    drain();
    scan_row(270, 90, 140);

    // lane 0 divided by 3, then undivided
    lane_period[0] = 4'd3;
    repeat (6) tick();
    scan_row(270, 94, 132);
    lane_period[0] = 4'd0;
    repeat (2) tick();
    scan_row(270, 96, 104);

    // collision with lane 0 car 0, cleared by the next tick
    frog_lane = 3'd0;
    frog_x    = 10'(pos[0][0] + 4);
    scan_row(265, pos[0][0] - 4, pos[0][0] + 40);
    chk("collide_set", collide, exp_collide);
    tick();
    repeat (2) @(negedge clk);
    chk("collide_cleared", collide, exp_collide);

    // reset in the middle of a scan with collide high
    frog_x = 10'(pos[0][0]);
    for (int c = 0; c < 6; c++) drive(pos[0][0] + c, 262);
    @(posedge clk);
    #3;
    chk("pre_reset_collide", collide, exp_collide);
    q.delete();
    reset_n    = 1'b0;
    pix.colPos = 10'd0;
    pix.rowPos = 10'd0;
    #1;
    chk("async_reset_color", pix.color, 0);
    chk("async_reset_car_hit", pix.car_hit, 0);
    chk("async_reset_collide", collide, 0);
    model_reset();
    exp_collide = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    scan_row(260, 94, 98);
    scan_row(260, 318, 322);
    tick();
    scan_row(260, 94, 99);

    // pause freezes motion
    frog_lane = 3'd7;
    pause = 1'b1;
    repeat (10) tick();
    pause = 1'b0;
    scan_cars();

    // right wrap on lane 1, left wrap on lane 2
    lane_length[1] = 10'd64; lane_dir[1] = 1'b1;
    lane_length[2] = 10'd64; lane_dir[2] = 1'b0;
    for (int n = 0; n < 600 && pos[2][0] != 33; n++) tick();
    scan_row(330, 94, 100);
    tick();
    scan_row(330, 536, 543);
    for (int n = 0; n < 600 && pos[1][1] != 543; n++) tick();
    scan_row(300, 536, 543);
    tick();
    scan_row(300, 94, 100);
    tick();
    scan_row(300, 94, 100);

    // randomized traffic, lengths, periods, frog placement
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NL; i++) begin
        lane_length[i] = 10'($urandom_range(96, 16));
        lane_period[i] = 4'($urandom_range(15, 0));
        lane_dir[i]    = 1'($urandom_range(1, 0));
      end
      repeat ($urandom_range(40, 1)) begin
        pause = ($urandom_range(7, 0) == 0);
        tick();
      end
      pause = 1'b0;
      frog_lane = 3'($urandom_range(7, 0));
      frog_x    = 10'($urandom_range(543, 96));
      for (int j = 0; j < 40; j++) begin
        case ($urandom_range(3, 0))
          0: begin row = $urandom_range(479, 0); col = $urandom_range(639, 0); end
          1: begin
               l = $urandom_range(NL - 1, 0); k = $urandom_range(NC - 1, 0);
               row = LANE_Y0 + l * BS + $urandom_range(BS - 1, 0);
               col = pos[l][k] + $urandom_range(int'(lane_length[l]) + 2, 0) - 2;
             end
          2: begin
               row = LANE_Y0 + int'(frog_lane) * BS + $urandom_range(BS - 1, 0);
               col = int'(frog_x) + $urandom_range(BS + 3, 0) - 2;
             end
          default: begin
               l = $urandom_range(NL - 1, 0);
               row = LANE_Y0 + l * BS + $urandom_range(BS - 1, 0);
               col = $urandom_range(X_RIGHT + 3, X_LEFT - 3);
             end
        endcase
        if (col < 0) col = 0;
        drive(col, row);
      end
      drain();
      chk("rand_collide", collide, exp_collide);
      tick();
      repeat (2) @(negedge clk);
      chk("rand_collide_clear", collide, exp_collide);
    end
    scan_cars();

    drain();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
